vx_mem_responder: RTL and testbench
===================================

// Module: vx_mem_responder
// PURPOSE
//  Memory-side responder for one VX_mem_bus_if port. It is the slave end of the L2/cluster memory master.
//  Backs a local line-wide SRAM. Byte-masked writes are absorbed with no response. Reads return data
//  after a fixed pipeline latency, in acceptance order, under rsp_ready backpressure.
//  Used as on-chip memory and as the bench sink; instantiate one per L2_MEM_PORTS port.
// PARAMETERS
//  LINE_SIZE    64   bytes per line; data width = 8*LINE_SIZE
//  ADDR_WIDTH   26   line-address width of req_addr
//  TAG_WIDTH    8    request/response tag width
//  DEPTH        1024 SRAM lines (power of 2); index = req_addr[log2(DEPTH)-1:0]
//  LATENCY      4    cycles from read acceptance to earliest rsp_valid (>=1)
//  RSPQ_SIZE    8    response queue entries = max outstanding reads (power of 2, >=2)
// PORTS
//  clk           in   1              clock
//  reset         in   1              asynchronous, active-low reset
//  req_valid     in   1              request valid
//  req_rw        in   1              1=write, 0=read
//  req_addr      in   ADDR_WIDTH     line address
//  req_byteen    in   LINE_SIZE      write byte enables
//  req_data      in   8*LINE_SIZE    write data
//  req_tag       in   TAG_WIDTH      request tag
//  req_ready     out  1              request accepted when valid&ready
//  rsp_valid     out  1              read response valid
//  rsp_data      out  8*LINE_SIZE    read data
//  rsp_tag       out  TAG_WIDTH      tag of originating read
//  rsp_ready     in   1              consumer ready
//  busy          out  1              any read outstanding
//  perf_reads    out  32             accepted reads, wraps
//  perf_writes   out  32             accepted writes, wraps
// BEHAVIOUR
//  - Reset asserted (reset==0): req_ready=0, rsp_valid=0, busy=0, perf_*=0, credits=0, pipe/queue cleared.
//    SRAM contents are not reset. Mid-operation reset drops all in-flight reads silently.
//  - Credit counter cnt (0..RSPQ_SIZE) counts accepted reads not yet popped from the queue.
//    req_ready = ~in_reset & (cnt < RSPQ_SIZE). Writes bypass the credit and are always accepted when ready.
//  - Accept write: SRAM[idx] bytes with byteen=1 updated at the clock edge; no response.
//  - Accept read: SRAM[idx] read in the accept cycle with write-first ordering relative to earlier accepts.
//    {data,tag} enters a LATENCY-stage valid-tagged shift pipe; at pipe exit it is pushed to the queue.
//  - A read accepted at edge T is visible as rsp_valid at edge T+LATENCY at the earliest; order = acceptance order.
//  - Pop on rsp_valid&rsp_ready. rsp_data/tag hold stable while rsp_valid&~rsp_ready.
//  - cnt: +1 on read accept, -1 on pop, unchanged when both in the same cycle.
//    Credits guarantee queue push never overflows; the pipe never stalls.
//  - Write and later read to same idx: read returns new data. Back-to-back reads: 1 per cycle.
//  - busy = (cnt != 0). Address bits above log2(DEPTH) ignored (aliasing wraps).
// STRUCTURE
//  - VX_gpu_pkg: add mem_rsp_entry_t {data,tag} typedef and
//    MEM_RESP_LATENCY_MIN=1 constant.
//  - Sub-module: response queue is VX_fifo_queue (DATAW=8*LINE_SIZE+TAG_WIDTH, DEPTH=RSPQ_SIZE).
//  - Pipe and SRAM are inline; SRAM uses per-byte write enable.
// TESTING
//  1. Reset release: after reset 0->1, req_ready=1 next cycle, rsp_valid=0, busy=0, perf_*=0.
//  2. Write addr 0x10, data=A5 pattern, byteen all ones; then read tag 3 -> rsp_tag=3 with A5 pattern.
//     rsp_valid arrives exactly LATENCY=4 cycles after read accept; perf_writes=1, perf_reads=1.
//  3. Partial write byteen=0x0F with data 0xFF to an all-zero line; read -> bytes 0..3=FF, rest=00.
//  4. rsp_ready=0 and 8 back-to-back reads (tags 0..7) -> req_ready drops after the 8th accept.
//     Raise rsp_ready -> tags 0..7 pop in order; req_ready returns 1 the cycle after the first pop.
//  5. Same-cycle read accept and pop with cnt=5 -> cnt stays 5. A write while cnt=8 is not accepted (req_ready=0).
//  6. Assert reset with 3 reads in flight -> rsp_valid=0 immediately (async).
//     After release none of the 3 responses appear; the SRAM keeps the data written before reset.

Source files
------------

// File: rtl/vx_mem_responder_pkg.sv
// Shared types and constants for the memory-side responder.
// The entry struct matches the default line/tag geometry.
package vx_mem_responder_pkg;

   localparam int MEM_RESP_LATENCY_MIN = 1;
   localparam int MEM_LINE_SIZE        = 64;
   localparam int MEM_TAG_WIDTH        = 8;

   typedef struct packed {
      logic [8*MEM_LINE_SIZE-1:0] data;
      logic [MEM_TAG_WIDTH-1:0]   tag;
   } mem_rsp_entry_t;

endpackage

// File: rtl/vx_mem_responder_fifo_queue.sv
// In-order response queue.
// Pointers carry one extra wrap bit so that full and empty can be told apart.
module vx_mem_responder_fifo_queue #(
   parameter int DATAW = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [DATAW-1:0] data_in,
   output logic [DATAW-1:0] data_out,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [DATAW-1:0] store [DEPTH];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) store[wr_ptr[AW-1:0]] <= data_in;
   end

   assign data_out = store[rd_ptr[AW-1:0]];
   assign empty    = (wr_ptr == rd_ptr);

endmodule

// File: rtl/vx_mem_responder.sv
// Memory-side responder: a byte-masked line SRAM with a fixed-latency read pipe.
// A credit-limited response queue returns read data under backpressure.
module vx_mem_responder
   import vx_mem_responder_pkg::*;
#(
   parameter int LINE_SIZE  = MEM_LINE_SIZE,
   parameter int ADDR_WIDTH = 26,
   parameter int TAG_WIDTH  = MEM_TAG_WIDTH,
   parameter int DEPTH      = 1024,
   parameter int LATENCY    = 4,
   parameter int RSPQ_SIZE  = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   req_valid,
   input  logic                   req_rw,
   input  logic [ADDR_WIDTH-1:0]  req_addr,
   input  logic [LINE_SIZE-1:0]   req_byteen,
   input  logic [8*LINE_SIZE-1:0] req_data,
   input  logic [TAG_WIDTH-1:0]   req_tag,
   output logic                   req_ready,
   output logic                   rsp_valid,
   output logic [8*LINE_SIZE-1:0] rsp_data,
   output logic [TAG_WIDTH-1:0]   rsp_tag,
   input  logic                   rsp_ready,
   output logic                   busy,
   output logic [31:0]            perf_reads,
   output logic [31:0]            perf_writes
);

   localparam int DATA_W = 8*LINE_SIZE;
   localparam int IDX_W  = $clog2(DEPTH);
   localparam int CNT_W  = $clog2(RSPQ_SIZE) + 1;
   localparam int ENT_W  = DATA_W + TAG_WIDTH;

   typedef struct packed {
      logic [DATA_W-1:0]    data;
      logic [TAG_WIDTH-1:0] tag;
   } rsp_entry_t;

   if (LATENCY < MEM_RESP_LATENCY_MIN) begin : g_bad_latency
      $error("vx_mem_responder: LATENCY below minimum");
   end

   logic             in_reset_q;
   logic [CNT_W-1:0] cnt;
   logic [IDX_W-1:0] idx;
   logic             wr_acc;
   logic             rd_acc;
   logic             rsp_pop;
   logic             rsp_empty;
   logic             unused_addr_hi;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [LATENCY-1:0] vld_p;
   rsp_entry_t       ent_p [LATENCY];
   rsp_entry_t       q_in;
   rsp_entry_t       q_out;

   // Upper address bits alias onto the same line.
   assign idx            = req_addr[IDX_W-1:0];
   assign unused_addr_hi = ^req_addr[ADDR_WIDTH-1:IDX_W];

   assign req_ready = ~in_reset_q & (cnt < CNT_W'(RSPQ_SIZE));
   assign wr_acc    = req_valid & req_ready & req_rw;
   assign rd_acc    = req_valid & req_ready & ~req_rw;
   assign rsp_pop   = rsp_valid & rsp_ready;
   assign busy      = (cnt != '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         in_reset_q  <= 1'b1;
         cnt         <= '0;
         perf_reads  <= '0;
         perf_writes <= '0;
      end else begin
         in_reset_q <= 1'b0;
         case ({rd_acc, rsp_pop})
            2'b10:   cnt <= cnt + CNT_W'(1);
            2'b01:   cnt <= cnt - CNT_W'(1);
            default: cnt <= cnt;
         endcase
         if (rd_acc) perf_reads  <= perf_reads + 32'd1;
         if (wr_acc) perf_writes <= perf_writes + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_acc) begin
         for (int b = 0; b < LINE_SIZE; b++) begin
            if (req_byteen[b]) mem[idx][8*b +: 8] <= req_data[8*b +: 8];
         end
      end
   end

   // Stage 0: SRAM read captured in the accept cycle, then a fixed shift toward the queue.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vld_p <= '0;
      end else begin
         vld_p[0] <= rd_acc;
         for (int i = 1; i < LATENCY; i++) vld_p[i] <= vld_p[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rd_acc) begin
         ent_p[0].data <= mem[idx];
         ent_p[0].tag  <= req_tag;
      end
      for (int i = 1; i < LATENCY; i++) ent_p[i] <= ent_p[i-1];
   end

   // Pipe exit: credits keep the queue from ever overflowing, so the push is unconditional.
   assign q_in = ent_p[LATENCY-1];

   vx_mem_responder_fifo_queue #(
      .DATAW (ENT_W),
      .DEPTH (RSPQ_SIZE)
   ) rsp_queue (
      .clk      (clk),
      .reset    (reset),
      .push     (vld_p[LATENCY-1]),
      .pop      (rsp_pop),
      .data_in  (q_in),
      .data_out (q_out),
      .empty    (rsp_empty)
   );

   assign rsp_valid = ~rsp_empty;
   assign rsp_data  = q_out.data;
   assign rsp_tag   = q_out.tag;

endmodule

// File: tb/tb_vx_mem_responder.sv
// Randomized and directed bench for vx_mem_responder against a queue-based reference model.
module tb_vx_mem_responder;

   localparam int LINE_SIZE  = 64;
   localparam int ADDR_WIDTH = 26;
   localparam int TAG_WIDTH  = 8;
   localparam int DEPTH      = 1024;
   localparam int LATENCY    = 4;
   localparam int RSPQ_SIZE  = 8;
   localparam int DW         = 8*LINE_SIZE;

   logic                  clk = 1'b0;
   logic                  reset = 1'b0;
   logic                  req_valid = 1'b0;
   logic                  req_rw = 1'b0;
   logic [ADDR_WIDTH-1:0] req_addr = '0;
   logic [LINE_SIZE-1:0]  req_byteen = '0;
   logic [DW-1:0]         req_data = '0;
   logic [TAG_WIDTH-1:0]  req_tag = '0;
   logic                  req_ready;
   logic                  rsp_valid;
   logic [DW-1:0]         rsp_data;
   logic [TAG_WIDTH-1:0]  rsp_tag;
   logic                  rsp_ready = 1'b0;
   logic                  busy;
   logic [31:0]           perf_reads;
   logic [31:0]           perf_writes;

   always #5 clk = ~clk;

   vx_mem_responder #(
      .LINE_SIZE  (LINE_SIZE),
      .ADDR_WIDTH (ADDR_WIDTH),
      .TAG_WIDTH  (TAG_WIDTH),
      .DEPTH      (DEPTH),
      .LATENCY    (LATENCY),
      .RSPQ_SIZE  (RSPQ_SIZE)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_rw      (req_rw),
      .req_addr    (req_addr),
      .req_byteen  (req_byteen),
      .req_data    (req_data),
      .req_tag     (req_tag),
      .req_ready   (req_ready),
      .rsp_valid   (rsp_valid),
      .rsp_data    (rsp_data),
      .rsp_tag     (rsp_tag),
      .rsp_ready   (rsp_ready),
      .busy        (busy),
      .perf_reads  (perf_reads),
      .perf_writes (perf_writes)
   );

   // Reference model: a line array, plus the outstanding reads in acceptance order with their due cycle.
   typedef struct {
      logic [DW-1:0]        data;
      logic [TAG_WIDTH-1:0] tag;
      int                   due;
   } exp_t;

   exp_t          q[$];
   logic [DW-1:0] mm [DEPTH];
   logic [31:0]   n_rd_m = '0;
   logic [31:0]   n_wr_m = '0;
   bit            in_rst_m = 1'b1;
   int            cyc = 0;
   int            tests = 0;
   int            fails = 0;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] rnd_line();
      logic [DW-1:0] d;
      for (int i = 0; i < DW/32; i++) d[32*i +: 32] = $urandom();
      return d;
   endfunction

   task automatic check_outputs(output bit exp_vld);
      exp_vld = (q.size() != 0) ? (q[0].due <= cyc) : 1'b0;
      check("req_ready", req_ready, !in_rst_m && (q.size() < RSPQ_SIZE));
      check("rsp_valid", rsp_valid, exp_vld);
      if (exp_vld) begin
         check("rsp_data", rsp_data, q[0].data);
         check("rsp_tag", rsp_tag, q[0].tag);
      end
      check("busy", busy, q.size() != 0);
      check("perf_reads", perf_reads, n_rd_m);
      check("perf_writes", perf_writes, n_wr_m);
   endtask

   // Called at a negedge: check, drive one cycle's inputs, advance the model across the posedge.
   task automatic cycle(input bit v, input bit rw, input logic [ADDR_WIDTH-1:0] addr,
                        input logic [LINE_SIZE-1:0] be, input logic [DW-1:0] d,
                        input logic [TAG_WIDTH-1:0] tag, input bit rr);
      bit exp_vld;
      bit exp_ready;
      check_outputs(exp_vld);
      exp_ready  = !in_rst_m && (q.size() < RSPQ_SIZE);
      req_valid  = v;
      req_rw     = rw;
      req_addr   = addr;
      req_byteen = be;
      req_data   = d;
      req_tag    = tag;
      rsp_ready  = rr;
      @(posedge clk);
      cyc++;
      if (reset) in_rst_m = 1'b0;
      if (exp_vld && rr) void'(q.pop_front());
      if (v && exp_ready) begin
         if (rw) begin
            for (int b = 0; b < LINE_SIZE; b++)
               if (be[b]) mm[addr[9:0]][8*b +: 8] = d[8*b +: 8];
            n_wr_m++;
         end else begin
            q.push_back('{data: mm[addr[9:0]], tag: tag, due: cyc + LATENCY});
            n_rd_m++;
         end
      end
      @(negedge clk);
   endtask

   task automatic idle(input bit rr);
      cycle(1'b0, 1'b0, '0, '0, '0, '0, rr);
   endtask

   task automatic rd(input logic [ADDR_WIDTH-1:0] addr, input logic [TAG_WIDTH-1:0] tag, input bit rr);
      cycle(1'b1, 1'b0, addr, '0, rnd_line(), tag, rr);
   endtask

   task automatic wr(input logic [ADDR_WIDTH-1:0] addr, input logic [LINE_SIZE-1:0] be,
                     input logic [DW-1:0] d, input bit rr);
      cycle(1'b1, 1'b1, addr, be, d, 8'hEE, rr);
   endtask

   task automatic do_reset();
      reset     = 1'b0;
      req_valid = 1'b0;
      #1;
      q.delete();
      n_rd_m   = '0;
      n_wr_m   = '0;
      in_rst_m = 1'b1;
      check("rst_rsp_valid", rsp_valid, 1'b0);
      check("rst_req_ready", req_ready, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_perf_reads", perf_reads, 32'd0);
      check("rst_perf_writes", perf_writes, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      logic [ADDR_WIDTH-1:0] a;
      logic [DW-1:0]         pat;

      // Reset and release
      repeat (2) @(negedge clk);
      do_reset();
      idle(1'b1);
      idle(1'b1);
      check("t1_ready_after_release", req_ready, 1'b1);

      // Full write then read, exact latency
      wr(26'h10, '1, {64{8'hA5}}, 1'b1);
      rd(26'h10, 8'd3, 1'b1);
      repeat (LATENCY + 2) idle(1'b1);
      check("t2_perf_writes", perf_writes, 32'd1);
      check("t2_perf_reads", perf_reads, 32'd1);

      // Partial write onto a zero line
      wr(26'h11, '1, '0, 1'b1);
      wr(26'h11, 64'h0F, '1, 1'b1);
      rd(26'h11, 8'd4, 1'b1);
      repeat (LATENCY + 2) idle(1'b1);
      check("t3_line", mm[10'h11], {{60{8'h00}}, {4{8'hFF}}});

      for (int i = 2; i < 16; i++) wr(26'h10 + 26'(i), '1, rnd_line(), 1'b1);

      // Fill all credits with the consumer stalled, then drain in order
      for (int t = 0; t < 8; t++) rd(26'h10 + 26'(t), 8'(t), 1'b0);
      check("t4_ready_dropped", req_ready, 1'b0);
      rd(26'h13, 8'd99, 1'b0);
      repeat (LATENCY) idle(1'b0);
      repeat (12) idle(1'b1);

      // Simultaneous accept and pop at five outstanding; write refused while full
      for (int t = 0; t < 5; t++) rd(26'h18 + 26'(t), 8'(20 + t), 1'b0);
      repeat (LATENCY) idle(1'b0);
      rd(26'h14, 8'd50, 1'b1);
      for (int t = 0; t < 3; t++) rd(26'h15 + 26'(t), 8'(60 + t), 1'b0);
      check("t5_full_ready", req_ready, 1'b0);
      wr(26'h12, '1, rnd_line(), 1'b0);
      repeat (14) idle(1'b1);
      rd(26'h12, 8'd70, 1'b1);
      repeat (LATENCY + 2) idle(1'b1);

      // Reset with reads in flight; SRAM must survive
      pat = rnd_line();
      wr(26'h15, '1, pat, 1'b1);
      for (int t = 0; t < 3; t++) rd(26'h15, 8'(80 + t), 1'b0);
      repeat (LATENCY + 1) idle(1'b0);
      check("t6_valid_before_reset", rsp_valid, 1'b1);
      do_reset();
      repeat (10) idle(1'b1);
      rd(26'h15, 8'd90, 1'b1);
      repeat (LATENCY + 1) idle(1'b1);
      check("t6_sram_kept", mm[10'h15], pat);

      // Random traffic with aliased upper address bits
      for (int n = 0; n < 600; n++) begin
         a[9:0]            = 10'h10 + 10'($urandom_range(0, 15));
         a[ADDR_WIDTH-1:10] = 16'($urandom());
         cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, a,
               {$urandom(), $urandom()}, rnd_line(), 8'($urandom()),
               $urandom_range(0, 3) != 0);
      end
      repeat (RSPQ_SIZE + LATENCY + 4) idle(1'b1);
      check("final_idle_busy", busy, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
